// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request arbiter slice.
//   ANG_W / XY_SZ : angle and sine-result widths of the shared CORDIC unit
//   ANG_PI2/ANG_PI: angle encodings for +pi/2 and pi (quadrant in [15:14])
//   rsp_entry_t   : response FIFO payload {requester id, signed sine}
package cordic_pkg;

  localparam int unsigned ANG_W    = 16;
  localparam int unsigned XY_SZ    = 8;
  // Id field sized for the largest supported requester count (8).
  localparam int unsigned ID_MAX_W = 3;

  localparam logic [ANG_W-1:0] ANG_PI2 = 16'h4000;
  localparam logic [ANG_W-1:0] ANG_PI  = 16'h8000;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [XY_SZ-1:0]    data;
  } rsp_entry_t;

  localparam int unsigned RSP_W = $bits(rsp_entry_t);

endpackage

// File: rtl/cordic_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
//   clk, rst   : clock, asynchronous active-high reset
//   push, din  : write request and payload
//   pop        : read request; head advances on the next edge
//   dout       : current head (valid while !empty)
//   empty/full : occupancy flags; count = number of stored entries
// Push and pop in the same cycle are legal at any occupancy, including full.
module cordic_rsp_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            din,
  input  logic                         pop,
  output logic [DATA_W-1:0]            dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         do_push, do_pop;

  // Pointer, storage and count update; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/cordic_req_arbiter.sv
// Round-robin arbiter sharing one fixed-latency CORDIC sine unit between
// NREQ requesters. Issued angles are tagged with the requester id; results
// are captured into a response FIFO. Issue is credit-limited so a result
// always has a FIFO slot when it emerges from the (non-stallable) CORDIC.
//   CLK_100MHZ, RST : clock, asynchronous active-high reset
//   req_valid/angle : per-requester angle requests (angle i at [i*ANG_W +: ANG_W])
//   req_ready       : one-hot grant, combinational from registered state
//   cordic_angle    : registered angle to the CORDIC
//   cordic_xout     : CORDIC result, valid CORDIC_LAT edges after cordic_angle
//   rsp_valid/ready : response handshake; rsp_id/rsp_data = FIFO head
//   busy            : a tag is in flight or the FIFO holds data
module cordic_req_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned CORDIC_LAT = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK_100MHZ,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*ANG_W-1:0] req_angle,
  output logic [NREQ-1:0]       req_ready,
  output logic [ANG_W-1:0]      cordic_angle,
  input  logic [XY_SZ-1:0]      cordic_xout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [XY_SZ-1:0]      rsp_data,
  output logic                  busy
);

  localparam int unsigned PIPE_N = CORDIC_LAT + 1;
  localparam int unsigned INF_W  = $clog2(CORDIC_LAT + 2);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [ANG_W-1:0]             angle_q, angle_d;
  logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [INF_W-1:0]             inflight_q, inflight_d;
  logic [PIPE_N-1:0]            tag_vld_q, tag_vld_d;
  logic [PIPE_N-1:0][ID_W-1:0]  tag_id_q, tag_id_d;

  logic                         has_credit_c;
  logic                         grant_vld_c;
  logic [ID_W-1:0]              grant_id_c;
  logic [ID_W-1:0]              idx_c;
  logic                         push_c;
  logic                         pop_c;
  rsp_entry_t                   push_entry_c;
  rsp_entry_t                   head_entry;
  logic [CNT_W-1:0]             fifo_count;
  logic                         fifo_empty;
  logic                         fifo_full;

  // Credit only counts registered occupancy; a same-cycle pop frees it next cycle.
  always_comb begin
    has_credit_c = (32'(inflight_q) + 32'(fifo_count)) < FIFO_DEPTH;
  end

  // Priority scan starting after the last winner; grant i only looks at
  // requesters ahead of it in the rotation.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    idx_c       = '0;
    req_ready   = '0;
    if (has_credit_c && !RST) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx_c = ID_W'((32'(rr_ptr_q) + k) % NREQ);
        if (!grant_vld_c && req_valid[idx_c]) begin
          grant_vld_c = 1'b1;
          grant_id_c  = idx_c;
        end
      end
      if (grant_vld_c) begin
        req_ready[grant_id_c] = 1'b1;
      end
    end
  end

  // Issue, tag pipe shift and in-flight bookkeeping.
  always_comb begin
    angle_d      = angle_q;
    rr_ptr_d     = rr_ptr_q;
    inflight_d   = inflight_q;
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = grant_vld_c;
    tag_id_d[0]  = grant_id_c;
    for (int unsigned s = 1; s < PIPE_N; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
    if (grant_vld_c) begin
      angle_d  = req_angle[32'(grant_id_c)*ANG_W +: ANG_W];
      rr_ptr_d = grant_id_c;
    end
    case ({grant_vld_c, push_c})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // The tag leaving the pipe lines up with the CORDIC result for its angle.
  always_comb begin
    push_c            = tag_vld_q[PIPE_N-1];
    pop_c             = rsp_ready && !fifo_empty;
    push_entry_c      = '0;
    push_entry_c.id   = ID_MAX_W'(tag_id_q[PIPE_N-1]);
    push_entry_c.data = cordic_xout;
  end

  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      angle_q    <= '0;
      rr_ptr_q   <= ID_W'(NREQ - 1);
      inflight_q <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
    end else begin
      angle_q    <= angle_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
    end
  end

  cordic_rsp_fifo #(
    .DATA_W (RSP_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (CLK_100MHZ),
    .rst   (RST),
    .push  (push_c),
    .din   (push_entry_c),
    .pop   (pop_c),
    .dout  (head_entry),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Credit accounting must make overflow impossible.
  a_no_overflow: assert property (@(posedge CLK_100MHZ) disable iff (RST)
    !(push_c && fifo_full && !pop_c));

  assign cordic_angle = angle_q;
  assign rsp_valid    = !fifo_empty;
  assign rsp_id       = head_entry.id[ID_W-1:0];
  assign rsp_data     = head_entry.data;
  assign busy         = (inflight_q != '0) || !fifo_empty;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
module tb_cordic_req_arbiter;
  import cordic_pkg::*;

  localparam int unsigned NREQ       = 4;
  localparam int unsigned CORDIC_LAT = 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ID_W       = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ANG_W-1:0] req_angle;
  logic [NREQ-1:0]       req_ready;
  logic [ANG_W-1:0]      cordic_angle;
  logic [XY_SZ-1:0]      cordic_xout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [XY_SZ-1:0]      rsp_data;
  logic                  busy;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct { int id; int data; } exp_t;
  exp_t sb[$];

  int grant_seq[5] = '{1, 2, 4, 8, 1};

  always #5 clk = ~clk;

  cordic_req_arbiter #(
    .NREQ       (NREQ),
    .CORDIC_LAT (CORDIC_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK_100MHZ   (clk),
    .RST          (rst),
    .req_valid    (req_valid),
    .req_angle    (req_angle),
    .req_ready    (req_ready),
    .cordic_angle (cordic_angle),
    .cordic_xout  (cordic_xout),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .busy         (busy)
  );

  // Behavioural CORDIC: scaled sine, one register stage.
  function automatic int model_sin(input logic [15:0] a);
    real r;
    r = 123.0 * $sin(6.283185307179586 * real'(a) / 65536.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) cordic_xout <= '0;
    else     cordic_xout <= XY_SZ'(model_sin(cordic_angle));
  end

  // Hand-computed golden sine values (123 * sin).
  function automatic int exp_sin(input logic [15:0] a);
    case (a)
      16'h0000: return 0;
      16'h2000: return 87;
      16'h4000: return 123;
      16'h6000: return 87;
      16'h8000: return 0;
      16'hA000: return -87;
      16'hC000: return -123;
      16'hE000: return -87;
      default:  return 999;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_chk++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d +-%0d", name, act, exp, tol);
  endtask

  // Scoreboard producer: each transfer yields one expected response.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.id   = i;
          e.data = exp_sin(req_angle[i*ANG_W +: ANG_W]);
          sb.push_back(e);
        end
      end
    end
  end

  // Scoreboard consumer: compare every accepted response against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected_id", int'(rsp_id), -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", int'(rsp_id), e.id);
        check_near("rsp_data", int'($signed(rsp_data)), e.data, 2);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_ang(input int i, input logic [15:0] a);
    req_angle[i*ANG_W +: ANG_W] = a;
  endtask

  // One-cycle reset with reset-state checks in the same cycle.
  task automatic do_reset(input string name);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    sb.delete();
    neg();
    check({name, "_rsp_valid"}, int'(rsp_valid), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_req_ready"}, int'(req_ready), 0);
    check({name, "_cordic_angle"}, int'(cordic_angle), 0);
    check({name, "_rsp_id"}, int'(rsp_id), 0);
    check({name, "_rsp_data"}, int'(rsp_data), 0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < 40) begin
      cyc();
      k++;
    end
    neg();
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_sb_left"}, sb.size(), 0);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_angle = '0;
    rsp_ready = 1'b0;
    repeat (2) cyc();
    do_reset("rst0");

    // 1: single requester, latency to rsp_valid
    set_ang(2, 16'h0000);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    neg(); check("t1_grant", int'(req_ready), 4);
    cyc(); req_valid = '0;
    neg(); check("t1_rsp_e0", int'(rsp_valid), 0); check("t1_busy", int'(busy), 1);
    cyc();
    neg(); check("t1_rsp_e1", int'(rsp_valid), 0);
    cyc();
    neg(); check("t1_rsp_e2", int'(rsp_valid), 1); check("t1_rsp_id", int'(rsp_id), 2);
    drain("t1");

    // 2: all requesting, round-robin from reset pointer
    do_reset("t2rst");
    set_ang(0, 16'h4000); set_ang(1, 16'hC000);
    set_ang(2, 16'h2000); set_ang(3, 16'h8000);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      neg(); check("t2_grant", int'(req_ready), grant_seq[k]);
      cyc();
    end
    req_valid = '0;
    neg(); check("t2_cordic_angle", int'(cordic_angle), 16'h4000);
    drain("t2");

    // 3 + 6: stalled consumer fills FIFO, then resume with pops from full
    do_reset("t3rst");
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      neg(); check("t3_fill_grant", int'(req_ready), 1 << k);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      neg(); check("t3_no_credit", int'(req_ready), 0);
      cyc();
    end
    neg();
    check("t3_busy", int'(busy), 1);
    check("t3_rsp_valid", int'(rsp_valid), 1);
    check("t3_head_id", int'(rsp_id), 0);
    check_near("t3_head_data", int'($signed(rsp_data)), 123, 2);
    cyc();
    neg(); check("t3_head_hold", int'(rsp_id), 0);
    cyc();
    rsp_ready = 1'b1;
    neg(); check("t3_pop_no_grant", int'(req_ready), 0);
    cyc();
    neg(); check("t3_resume_g0", int'(req_ready), 1);
    cyc();
    neg(); check("t3_resume_g1", int'(req_ready), 2);
    cyc();
    neg(); check("t3_resume_g2", int'(req_ready), 4);
    cyc();
    req_valid = '0;
    drain("t3");

    // 4: +pi/2 then -pi/2 on one requester
    do_reset("t4rst");
    rsp_ready = 1'b1;
    set_ang(1, 16'h4000);
    req_valid = 4'b0010;
    neg(); check("t4_grant_a", int'(req_ready), 2);
    cyc(); req_valid = '0;
    drain("t4a");
    set_ang(1, 16'hC000);
    req_valid = 4'b0010;
    neg(); check("t4_grant_b", int'(req_ready), 2);
    cyc(); req_valid = '0;
    drain("t4b");

    // 5: reset with two tags in flight discards them
    rsp_ready = 1'b1;
    set_ang(0, 16'h2000); set_ang(1, 16'h2000);
    req_valid = 4'b0011;
    cyc();
    cyc();
    do_reset("t5");
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      neg();
      check("t5_no_rsp", int'(rsp_valid), 0);
      check("t5_idle", int'(busy), 0);
      cyc();
    end

    neg(); check("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
